// File: rtl/alu_cmd_engine.sv
// alu_cmd_engine: FIFO-buffered command front-end for the 3-bit-opcode ALU with accumulator chaining
module alu_cmd_engine #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [WIDTH-1:0]           cmd_a,
  input  logic [WIDTH-1:0]           cmd_b,
  input  logic                       cmd_acc,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH:0]             rsp_out,
  output logic                       rsp_zero,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [CNT_W-1:0]           op_count
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [2:0]       op;
    logic             acc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;
  cmd_t             mem_q [DEPTH];
  cmd_t             head;
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic [WIDTH-1:0] acc_q, opa;
  logic [WIDTH:0]   out_q, res_d, ae, be;
  logic             valid_q, zero_q, push, issue;
  logic [CNT_W-1:0] ops_q;
  // DEPTH is a power of two, so the count's top bit alone marks a full FIFO
  assign cmd_ready  = !rst && !cnt_q[AW];
  assign push       = cmd_valid && cmd_ready;
  assign issue      = (cnt_q != '0) && (!valid_q || rsp_ready);
  assign head       = mem_q[rd_q];
  assign opa        = head.acc ? acc_q : head.a;
  assign ae         = {1'b0, opa};
  assign be         = {1'b0, head.b};
  assign rsp_valid  = valid_q;
  assign rsp_out    = out_q;
  assign rsp_zero   = zero_q;
  assign fifo_count = cnt_q;
  assign op_count   = ops_q;
  always_comb begin
    res_d = '0;
    case (head.op)
      3'd0:    res_d = ae + be;
      3'd1:    res_d = ae - be;
      3'd2:    res_d = ae | be;
      3'd3:    res_d = ae & be;
      3'd4:    res_d = ae ^ be;
      3'd5:    res_d = {1'b0, ~(opa | head.b)};
      3'd6:    res_d = {1'b0, ~(opa & head.b)};
      default: res_d = {1'b0, ~(opa ^ head.b)};
    endcase
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= '{op: cmd_op, acc: cmd_acc, a: cmd_a, b: cmd_b};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      ops_q   <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(issue);
      if (issue) begin
        rd_q    <= rd_q + AW'(1);
        acc_q   <= res_d[WIDTH-1:0];
        out_q   <= res_d;
        zero_q  <= (res_d[WIDTH-1:0] == '0);
        valid_q <= 1'b1;
        ops_q   <= ops_q + CNT_W'(1);
      end else if (rsp_ready) begin
        valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_cmd_engine.sv
// tb_alu_cmd_engine: scoreboard bench; driver pushes expected results, monitor pops on each response handshake
module tb_alu_cmd_engine;
  logic       clk = 1'b0;
  logic       rst, cmd_valid, cmd_ready, cmd_acc, rsp_valid, rsp_ready, rsp_zero;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic [8:0] rsp_out;
  logic [2:0] fifo_count;
  logic [15:0] op_count;
  logic [8:0] q[$];
  logic [7:0] macc;
  logic       rand_rdy = 1'b0;
  int n_cmp = 0, n_fail = 0;

  alu_cmd_engine #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
    .rsp_zero(rsp_zero), .fifo_count(fifo_count), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a | b};
      3'd3:    return {1'b0, a & b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~(a | b)};
      3'd6:    return {1'b0, ~(a & b)};
      default: return {1'b0, ~(a ^ b)};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rsp_extra: unexpected result 0x%0h at %0t", rsp_out, $time);
      end else begin
        logic [8:0] e;
        e = q.pop_front();
        chk("rsp_out", rsp_out, e);
        chk("rsp_zero", rsp_zero, e[7:0] == 8'h00);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
  end

  // Called just after a rising edge; returns just after the edge that accepted the command.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic acc, input logic use_exp, input logic [8:0] exp);
    logic [8:0] e;
    int t = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = acc;
    @(negedge clk);
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready stuck at 0 after %0d cycles", t);
    end else begin
      e = use_exp ? exp : alu(op, acc ? macc : a, b);
      macc = e[7:0];
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((q.size() != 0 || rsp_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    macc = 8'h00;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_n;
    logic [8:0] held;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; macc = 8'h00;
    cmd_op = 3'd0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_acc = 1'b0;
    #2;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_out", rsp_out, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_op_count", op_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;

    // Test 1: carry out, zero flag on low bits, single-cycle valid
    send(3'd0, 8'hFF, 8'h01, 1'b0, 1'b1, 9'h100);
    @(negedge clk); chk("t1_no_bypass", rsp_valid, 0);
    @(negedge clk); chk("t1_valid", rsp_valid, 1);
    @(negedge clk); chk("t1_valid_drop", rsp_valid, 0);
    chk("t1_op_count", op_count, 1);

    // Test 2: borrow and NOR-to-zero
    @(posedge clk); #1;
    send(3'd1, 8'h05, 8'h07, 1'b0, 1'b1, 9'h1FE);
    send(3'd5, 8'hF0, 8'h0F, 1'b0, 1'b1, 9'h000);
    wait_drain();

    // Test 3: back-to-back accumulator chaining
    @(posedge clk); #1;
    send(3'd0, 8'h03, 8'h04, 1'b0, 1'b1, 9'h007);
    send(3'd0, 8'h00, 8'h0A, 1'b1, 1'b1, 9'h011);
    send(3'd4, 8'h00, 8'hFF, 1'b1, 1'b1, 9'h0EE);
    @(negedge clk); chk("t3_consec1", rsp_valid, 1);
    @(negedge clk); chk("t3_consec2", rsp_valid, 1);
    @(negedge clk); chk("t3_consec_end", rsp_valid, 0);
    wait_drain();

    // Test 4: backpressure fills output register plus FIFO
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    acc_n = 0;
    for (int k = 0; k < 10; k++) begin
      cmd_valid = 1'b1; cmd_op = 3'(acc_n); cmd_a = 8'(8'h30 + acc_n); cmd_b = 8'(8'h11 * (acc_n + 1)); cmd_acc = 1'b0;
      @(negedge clk);
      if (cmd_ready) begin
        q.push_back(alu(cmd_op, cmd_a, cmd_b));
        macc = q[$][7:0];
        acc_n++;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t4_accepted", acc_n, 5);
    chk("t4_fifo_full", fifo_count, 4);
    chk("t4_cmd_ready_low", cmd_ready, 0);
    chk("t4_valid_held", rsp_valid, 1);
    held = q[0];
    chk("t4_out_held", rsp_out, held);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk); chk("t4_ready_still_low", cmd_ready, 0);
    @(negedge clk); chk("t4_ready_reassert", cmd_ready, 1);
    wait_drain();

    // Test 5: 1000 random commands under random valid/ready
    do_reset();
    rand_rdy = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 9'h000);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_drain();
    chk("t5_op_count", op_count, 1000);

    // Test 6: asynchronous reset mid-stream
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(3'd0, 8'(k), 8'h01, 1'b0, 1'b0, 9'h000);
    chk("t6_fifo3", fifo_count, 3);
    chk("t6_valid", rsp_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", rsp_valid, 0);
    chk("t6_rst_out", rsp_out, 0);
    chk("t6_rst_fifo", fifo_count, 0);
    chk("t6_rst_ready", cmd_ready, 0);
    chk("t6_rst_op_count", op_count, 0);
    q.delete();
    macc = 8'h00;
    @(posedge clk); #1 rst = 1'b0;
    rsp_ready = 1'b1;
    send(3'd0, 8'hAA, 8'h05, 1'b1, 1'b1, 9'h005);
    wait_drain();
    chk("t6_op_count", op_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
